// File: rtl/versat_multi_adder_pkg.sv
// Shared encodings for the Versat multi-operand adder unit: operating modes and FSM states.
package versat_multi_adder_pkg;

  typedef enum logic [1:0] {
    MODE_SUM     = 2'd0,
    MODE_ACCUM   = 2'd1,
    MODE_ALTSIGN = 2'd2,
    MODE_RSVD    = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DELAY  = 2'd1,
    ACTIVE = 2'd2,
    FINISH = 2'd3
  } state_e;

endpackage

// File: rtl/versat_multi_adder_tree.sv
// Combinational masked reduction of N_IN signed lanes; with alt_i set, odd lanes are subtracted.
module versat_multi_adder_tree #(
  parameter int DATA_W = 32,
  parameter int N_IN   = 4,
  parameter int SUM_W  = DATA_W + $clog2(N_IN)
) (
  input  logic [N_IN*DATA_W-1:0] in_flat_i,
  input  logic [N_IN-1:0]        mask_i,
  input  logic                   alt_i,
  output logic signed [SUM_W-1:0] sum_o
);

  logic signed [SUM_W-1:0]  acc_v;
  logic signed [DATA_W-1:0] raw_v;

  always_comb begin
    acc_v = '0;
    raw_v = '0;
    for (int i = 0; i < N_IN; i++) begin
      raw_v = in_flat_i[i*DATA_W +: DATA_W];
      if (mask_i[i]) begin
        if (alt_i && (i % 2 == 1)) acc_v = acc_v - SUM_W'(raw_v);
        else                       acc_v = acc_v + SUM_W'(raw_v);
      end
    end
    sum_o = acc_v;
  end

endmodule

// File: rtl/versat_multi_adder.sv
// Versat adder unit: run/done FSM, delay and length counters, accumulator and memory-mapped port.
// Define VERSAT_ADDER_SAT_EN for saturating accumulator updates and a sticky sat_flag output.
module versat_multi_adder
  import versat_multi_adder_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int N_IN   = 4,
  parameter int CNT_W  = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   run,
  output logic                   done,
  input  logic [N_IN*DATA_W-1:0] in_flat,
  input  logic [N_IN-1:0]        in_mask,
  input  logic [1:0]             mode,
  input  logic [CNT_W-1:0]       delay0,
  input  logic [CNT_W-1:0]       length,
  output logic [DATA_W-1:0]      currentValue,
  input  logic                   valid,
  input  logic [DATA_W/8-1:0]    wstrb,
  input  logic [DATA_W-1:0]      wdata,
  output logic                   ready,
  output logic [DATA_W-1:0]      rdata,
`ifdef VERSAT_ADDER_SAT_EN
  output logic                   sat_flag,
`endif
  output state_e                 state_o
);

  localparam int SUM_W = DATA_W + $clog2(N_IN);
`ifdef VERSAT_ADDER_SAT_EN
  localparam int EXT_W = SUM_W + 1;
`else
  localparam int EXT_W = DATA_W;
`endif

  state_e             state_q, state_d;
  mode_e              mode_q, mode_d;
  logic [N_IN-1:0]    mask_q, mask_d;
  logic [CNT_W-1:0]   dly_q, dly_d, len_q, len_d;
  logic [DATA_W-1:0]  acc_q, acc_d, rdata_q, rdata_d;
  logic               done_q, done_d, ready_q, ready_d;
  logic               sat_q, sat_d;

  logic signed [SUM_W-1:0] tree_sum;
  logic signed [EXT_W-1:0] upd_ext;
  logic [DATA_W-1:0]       upd_val;
  logic                    upd_clamp;

  versat_multi_adder_tree #(
    .DATA_W (DATA_W),
    .N_IN   (N_IN),
    .SUM_W  (SUM_W)
  ) u_tree (
    .in_flat_i (in_flat),
    .mask_i    (mask_q),
    .alt_i     (mode_q == MODE_ALTSIGN),
    .sum_o     (tree_sum)
  );

  // Next accumulator value for one sample; only ACCUM folds in the previous value.
  always_comb begin
    upd_ext = EXT_W'(tree_sum);
    if (mode_q == MODE_ACCUM) upd_ext = upd_ext + EXT_W'($signed(acc_q));
    upd_val   = upd_ext[DATA_W-1:0];
    upd_clamp = 1'b0;
`ifdef VERSAT_ADDER_SAT_EN
    if (!((&upd_ext[EXT_W-1:DATA_W-1]) || !(|upd_ext[EXT_W-1:DATA_W-1]))) begin
      upd_clamp = 1'b1;
      upd_val   = upd_ext[EXT_W-1] ? {1'b1, {(DATA_W-1){1'b0}}} : {1'b0, {(DATA_W-1){1'b1}}};
    end
`endif
  end

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    mask_d  = mask_q;
    dly_d   = dly_q;
    len_d   = len_q;
    acc_d   = acc_q;
    done_d  = done_q;
    sat_d   = sat_q;
    if (run) begin
      mode_d = mode_e'(mode);
      mask_d = in_mask;
      dly_d  = delay0;
      len_d  = length;
      done_d = 1'b0;
      sat_d  = 1'b0;
      if (mode_e'(mode) == MODE_ACCUM) acc_d = '0;
      if (delay0 != '0)      state_d = DELAY;
      else if (length != '0) state_d = ACTIVE;
      else                   state_d = FINISH;
    end else begin
      case (state_q)
        IDLE: begin
          if (valid && (|wstrb)) acc_d = wdata;
        end
        DELAY: begin
          dly_d = dly_q - 1'b1;
          if (dly_q == CNT_W'(1)) state_d = (len_q != '0) ? ACTIVE : FINISH;
        end
        ACTIVE: begin
          acc_d = upd_val;
          sat_d = sat_q | upd_clamp;
          len_d = len_q - 1'b1;
          // The last sample completes directly so done rises with the final result.
          if (len_q == CNT_W'(1)) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end
        FINISH: begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Memory-mapped port: valid/ready handshake, one-cycle ready pulse, read data is acc at request.
  always_comb begin
    ready_d = valid && !ready_q;
    rdata_d = ready_d ? acc_q : rdata_q;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      mode_q  <= MODE_SUM;
      mask_q  <= '0;
      dly_q   <= '0;
      len_q   <= '0;
      acc_q   <= '0;
      done_q  <= 1'b1;
      sat_q   <= 1'b0;
      ready_q <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      mask_q  <= mask_d;
      dly_q   <= dly_d;
      len_q   <= len_d;
      acc_q   <= acc_d;
      done_q  <= done_d;
      sat_q   <= sat_d;
      ready_q <= ready_d;
      rdata_q <= rdata_d;
    end
  end

  assign done         = done_q;
  assign currentValue = acc_q;
  assign ready        = ready_q;
  assign rdata        = rdata_q;
  assign state_o      = state_q;
`ifdef VERSAT_ADDER_SAT_EN
  assign sat_flag     = sat_q;
`else
  logic unused_sat;
  assign unused_sat = sat_q | upd_clamp;
`endif

endmodule

// File: tb/tb_versat_multi_adder.sv
// Bench for versat_multi_adder: vector table of runs plus hand sequences for timing, MM port and reset.
module tb_versat_multi_adder;
  import versat_multi_adder_pkg::*;

  localparam int DW = 32;
  localparam int NI = 4;
  localparam int CW = 16;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              run = 1'b0;
  logic              done;
  logic [NI*DW-1:0]  in_flat = '0;
  logic [NI-1:0]     in_mask = '0;
  logic [1:0]        mode = 2'd0;
  logic [CW-1:0]     delay0 = '0;
  logic [CW-1:0]     length = '0;
  logic [DW-1:0]     currentValue;
  logic              valid = 1'b0;
  logic [DW/8-1:0]   wstrb = '0;
  logic [DW-1:0]     wdata = '0;
  logic              ready;
  logic [DW-1:0]     rdata;
  state_e            state_o;
`ifdef VERSAT_ADDER_SAT_EN
  logic              sat_flag;
`endif

  versat_multi_adder #(.DATA_W(DW), .N_IN(NI), .CNT_W(CW)) dut (
    .clk          (clk),
    .rst          (rst),
    .run          (run),
    .done         (done),
    .in_flat      (in_flat),
    .in_mask      (in_mask),
    .mode         (mode),
    .delay0       (delay0),
    .length       (length),
    .currentValue (currentValue),
    .valid        (valid),
    .wstrb        (wstrb),
    .wdata        (wdata),
    .ready        (ready),
    .rdata        (rdata),
`ifdef VERSAT_ADDER_SAT_EN
    .sat_flag     (sat_flag),
`endif
    .state_o      (state_o)
  );

  // clock / reset
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  logic [DW-1:0] exp_q[$];

  typedef struct {
    logic [1:0]       mode;
    logic [NI-1:0]    mask;
    logic [NI*DW-1:0] lanes;
    logic [CW-1:0]    d0;
    logic [CW-1:0]    len;
    logic [DW-1:0]    exp;
  } vec_t;

  localparam int N_VEC = 16;
  vec_t vecs[N_VEC];

  localparam logic [NI*DW-1:0] L1234  = {32'd4, 32'd3, 32'd2, 32'd1};
  localparam logic [NI*DW-1:0] LFIVES = {32'd5, 32'd5, 32'd5, 32'd5};
  localparam logic [NI*DW-1:0] LONES  = {32'd1, 32'd1, 32'd1, 32'd1};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic wait_done(input int budget, output int cyc);
    cyc = 0;
    while (done !== 1'b1 && cyc < budget) begin
      tick();
      cyc++;
    end
    if (done !== 1'b1) begin
      n_tests++;
      n_fail++;
      $display("FAIL done_timeout: done still 0 after %0d cycles", cyc);
    end
  endtask

  task automatic start(input logic [1:0] m, input logic [NI-1:0] mk, input logic [NI*DW-1:0] l,
                       input logic [CW-1:0] d, input logic [CW-1:0] n);
    mode = m; in_mask = mk; in_flat = l; delay0 = d; length = n;
    run = 1'b1;
    tick();
    run = 1'b0;
  endtask

  // Issue one request; reads push the expected value and pop it when ready arrives.
  task automatic mm_req(input logic wr, input logic [DW-1:0] data, input logic [DW-1:0] exp_rd);
    logic [DW-1:0] e;
    valid = 1'b1;
    wstrb = wr ? 4'hF : 4'h0;
    wdata = data;
    if (!wr) exp_q.push_back(exp_rd);
    tick();
    valid = 1'b0;
    wstrb = '0;
    check("mm_ready", 64'(ready), 64'd1);
    if (!wr) begin
      e = exp_q.pop_front();
      check("mm_rdata", 64'(rdata), 64'(e));
    end
    tick();
    check("mm_ready_pulse", 64'(ready), 64'd0);
  endtask

  function automatic logic [DW-1:0] model(input logic [1:0] m, input logic [NI-1:0] mk,
                                          input logic [NI*DW-1:0] l, input int len);
    longint s;
    logic signed [DW-1:0] v;
    s = 0;
    for (int i = 0; i < NI; i++) begin
      v = l[i*DW +: DW];
      if (mk[i]) begin
        if (m == 2'd2 && (i % 2) == 1) s = s - longint'(v);
        else                           s = s + longint'(v);
      end
    end
    if (m == 2'd1) s = s * len;
    return DW'(s);
  endfunction

  initial begin
    int cyc;
    logic [DW-1:0] e;

    vecs[0] = '{2'd0, 4'hF,    L1234,  16'd0, 16'd1, 32'd10};
    vecs[1] = '{2'd1, 4'b0011, LFIVES, 16'd3, 16'd4, 32'd40};
    vecs[2] = '{2'd2, 4'hF, {32'd2, 32'd7, 32'd3, 32'd10}, 16'd0, 16'd1, 32'd12};
    vecs[3] = '{2'd2, 4'hF, {32'd0, 32'd0, 32'h7FFFFFFF, 32'd0}, 16'd1, 16'd2, 32'h80000001};
    vecs[4] = '{2'd0, 4'b1010, {32'd7, 32'd1000, 32'd100, 32'd1}, 16'd2, 16'd3, 32'd107};
    vecs[5] = '{2'd1, 4'hF, {4{32'hFFFFFFFF}}, 16'd0, 16'd3, 32'hFFFFFFF4};
    vecs[6] = '{2'd3, 4'hF, LONES, 16'd0, 16'd1, 32'd4};
    vecs[7] = '{2'd0, 4'h0, {4{32'd9}}, 16'd1, 16'd1, 32'd0};
    vecs[8] = '{2'd1, 4'hF, {4{32'h7FFFFFFF}}, 16'd0, 16'd2, 32'hFFFFFFF8};
    vecs[9] = '{2'd2, 4'b0010, {32'd0, 32'd0, 32'd5, 32'd0}, 16'd0, 16'd1, 32'hFFFFFFFB};
    for (int i = 10; i < N_VEC; i++) begin
      vecs[i].mode  = 2'($urandom_range(0, 3));
      vecs[i].mask  = 4'($urandom_range(0, 15));
      vecs[i].lanes = {$urandom(), $urandom(), $urandom(), $urandom()};
      vecs[i].d0    = 16'($urandom_range(0, 3));
      vecs[i].len   = 16'($urandom_range(1, 4));
      vecs[i].exp   = model(vecs[i].mode, vecs[i].mask, vecs[i].lanes, int'(vecs[i].len));
    end

    repeat (3) tick();
    rst = 1'b1;
    check("reset_done", 64'(done), 64'd1);
    check("reset_acc", 64'(currentValue), 64'd0);
    check("reset_ready", 64'(ready), 64'd0);
    check("reset_rdata", 64'(rdata), 64'd0);
    check("reset_state", 64'(state_o), 64'(IDLE));

    for (int i = 0; i < N_VEC; i++) begin
      start(vecs[i].mode, vecs[i].mask, vecs[i].lanes, vecs[i].d0, vecs[i].len);
      exp_q.push_back(vecs[i].exp);
      check($sformatf("vec%0d_busy", i), 64'(done), 64'd0);
      wait_done(64, cyc);
      check($sformatf("vec%0d_latency", i), 64'(cyc), 64'(vecs[i].d0) + 64'(vecs[i].len));
      e = exp_q.pop_front();
      check($sformatf("vec%0d_result", i), 64'(currentValue), 64'(e));
      check($sformatf("vec%0d_state", i), 64'(state_o), 64'(IDLE));
    end

    // ACCUM with start delay: nothing moves for three cycles, first sample on the fourth
    start(2'd1, 4'b0011, LFIVES, 16'd3, 16'd4);
    for (int k = 0; k < 3; k++) begin
      tick();
      check("delay_hold", 64'(currentValue), 64'd0);
    end
    tick();
    check("delay_first_update", 64'(currentValue), 64'd10);
    wait_done(16, cyc);
    check("delay_final", 64'(currentValue), 64'd40);

    // memory-mapped write/read in IDLE, then write dropped while ACTIVE
    mm_req(1'b1, 32'h1234, '0);
    check("mm_write_idle", 64'(currentValue), 64'h1234);
    mm_req(1'b0, '0, 32'h1234);
    start(2'd0, 4'hF, L1234, 16'd0, 16'd10);
    tick();
    mm_req(1'b1, 32'hDEAD, '0);
    mm_req(1'b0, '0, 32'd10);
    check("mm_write_busy_state", 64'(state_o), 64'(ACTIVE));
    wait_done(32, cyc);
    check("mm_write_busy_dropped", 64'(currentValue), 64'd10);

    // length=0: done low for one cycle, accumulator untouched
    mm_req(1'b1, 32'h55, '0);
    start(2'd0, 4'hF, L1234, 16'd0, 16'd0);
    check("len0_done_low", 64'(done), 64'd0);
    check("len0_state", 64'(state_o), 64'(FINISH));
    tick();
    check("len0_done_high", 64'(done), 64'd1);
    check("len0_acc", 64'(currentValue), 64'h55);
    start(2'd1, 4'hF, L1234, 16'd2, 16'd0);
    wait_done(16, cyc);
    check("len0_delay_latency", 64'(cyc), 64'd3);
    check("len0_accum_cleared", 64'(currentValue), 64'd0);

    // restart mid-ACCUM
    start(2'd1, 4'hF, LONES, 16'd0, 16'd10);
    tick();
    tick();
    check("restart_pre", 64'(currentValue), 64'd8);
    start(2'd1, 4'b0001, LONES, 16'd0, 16'd2);
    check("restart_clear", 64'(currentValue), 64'd0);
    wait_done(16, cyc);
    check("restart_latency", 64'(cyc), 64'd2);
    check("restart_final", 64'(currentValue), 64'd2);

    // run and write on the same edge: run wins, write acknowledged
    mode = 2'd0; in_mask = 4'hF; in_flat = L1234; delay0 = '0; length = 16'd1;
    run = 1'b1; valid = 1'b1; wstrb = 4'hF; wdata = 32'h999;
    tick();
    run = 1'b0; valid = 1'b0; wstrb = '0;
    check("runwr_ready", 64'(ready), 64'd1);
    check("runwr_acc", 64'(currentValue), 64'd2);
    tick();
    check("runwr_final", 64'(currentValue), 64'd10);
    check("runwr_done", 64'(done), 64'd1);

    // reset mid-ACTIVE with a read pending
    start(2'd0, 4'hF, L1234, 16'd0, 16'd10);
    tick();
    tick();
    rst = 1'b0; valid = 1'b1; wstrb = '0;
    tick();
    rst = 1'b1; valid = 1'b0;
    check("rst_mid_acc", 64'(currentValue), 64'd0);
    check("rst_mid_done", 64'(done), 64'd1);
    check("rst_mid_state", 64'(state_o), 64'(IDLE));
    check("rst_mid_ready", 64'(ready), 64'd0);
    tick();
    check("rst_mid_no_ready", 64'(ready), 64'd0);

    check("scoreboard_drain", 64'(exp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
